v_mul_seq: RTL
==============

// Module: v_mul_seq
// PURPOSE
//   Sequencer directly upstream of v_mul. Accepts one vector multiply (vd = vs1 * vs2, low SEW bits)
//   over VLEN-bit registers and streams one 32-bit word per cycle into v_mul. It tracks the multiplier
//   pipeline latency and reassembles the returned words into vd. Tail elements (index >= vl) keep vd_old.
// PARAMETERS
//   VLEN     128  vector register width in bits; multiple of 32; NW = VLEN/32 words
//   MUL_LAT  2    cycles from operands driven on mul_op_a/b to matching mul_result
// PORTS
//   clk         in   1                    clock; all state updates on rising edge
//   nrst        in   1                    reset; synchronous, active-high (nrst=1 resets on next clk edge)
//   start       in   1                    launch request; sampled only in IDLE
//   sew         in   2                    00=8b, 01=16b, 10=32b, 11=illegal
//   vl          in   $clog2(VLEN/8)+1     active element count, 0..VLEN/8
//   vs1, vs2    in   VLEN                 source vectors; element i at bits [i*SEW +: SEW]
//   vd_old      in   VLEN                 prior destination value, supplies tail elements
//   busy        out  1                    high from the cycle after accepted start until done
//   done        out  1                    one-cycle pulse; vd valid and stable from this cycle
//   vd          out  VLEN                 result vector; holds until next accepted start
//   mul_op_a    out  32                   word to v_mul op_A
//   mul_op_b    out  32                   word to v_mul op_B
//   mul_sew     out  2                    to v_mul sew; latched sew, constant across the operation
//   mul_is_mul  out  1                    to v_mul is_mul; high throughout ISSUE and DRAIN
//   mul_result  in   32                   v_mul result, MUL_LAT cycles after operands
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, vd=0, mul_op_a/b=0, mul_sew=0, mul_is_mul=0; valid pipe cleared.
//   Reset mid-operation aborts: no done pulse, captured results discarded.
//   FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   IDLE: on start, latch sew, vl, vs1, vs2, vd_old; compute nwords = ceil(vl*SEW/32).
//     If vl==0 or sew==11, go to DONE with vd=vd_old; never assert mul_is_mul. Otherwise go to ISSUE.
//   start while not IDLE is ignored. Inputs change freely after acceptance.
//   ISSUE: in cycle k (k=0..nwords-1), drive word k of vs1/vs2 on mul_op_a/b.
//     Push {valid=1, idx=k} into a MUL_LAT-deep shift pipe. After word nwords-1, go to DRAIN.
//   DRAIN: push valid=0; when the pipe is empty (all issued words captured), go to DONE.
//   Capture: when pipe output is valid with idx=j, write vd word j from mul_result, per element.
//     Elements per word epw = 4>>sew. Element e takes mul_result when j*epw+e < vl; else the vd_old bits.
//     Words never issued (j >= nwords) are loaded from vd_old at start.
//   Capture happens in any state incl. the ISSUE/DRAIN overlap; at most one word per cycle.
//   DONE: done=1 for exactly one cycle, busy=0; next state IDLE. A start in that cycle is ignored.
//   Timing (start accepted at edge T): word k is issued in cycle T+1+k and captured at the end of cycle T+1+k+MUL_LAT.
//     done is high in cycle T+nwords+MUL_LAT+1. For vl==0 or illegal sew, done is high in cycle T+1.
//   Arithmetic is a pure pass-through of v_mul's low-SEW product; no saturation or widening here.
// TESTING
//   1 sew=00, vl=16, vs1 bytes 0x03, vs2 bytes 0xFB -> vd all bytes 0xF1; done exactly at T+7 (VLEN=128, MUL_LAT=2).
//   2 sew=01, vl=3, vs1 halves 0x0010, vs2 halves 0x0020, vd_old 0xAAAA.. -> halves0-2=0x0200, halves3-7=0xAAAA; done at T+5.
//   3 sew=10, vl=4, vs1 words 0x7FFFFFFF, vs2 words 0x2 -> vd words 0xFFFFFFFE; mul_is_mul high T+1..T+6.
//   4 vl=0, then separately sew=11 -> done at T+1, vd==vd_old, mul_is_mul stays 0.
//   5 start pulsed every cycle during ISSUE -> ignored; result and done timing identical to single start.
//   6 nrst=1 in ISSUE -> next cycle IDLE, vd=0, busy=0, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/v_mul_seq.sv
// Vector multiply sequencer: issues VLEN-bit operands to v_mul one 32-bit word per cycle,
// tracks the multiplier latency and reassembles returned words into vd, keeping tail elements.
module v_mul_seq #(
    parameter int VLEN    = 128,
    parameter int MUL_LAT = 2
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic [1:0]                sew,
    input  logic [$clog2(VLEN/8):0]   vl,
    input  logic [VLEN-1:0]           vs1,
    input  logic [VLEN-1:0]           vs2,
    input  logic [VLEN-1:0]           vd_old,
    output logic                      busy,
    output logic                      done,
    output logic [VLEN-1:0]           vd,
    output logic [31:0]               mul_op_a,
    output logic [31:0]               mul_op_b,
    output logic [1:0]                mul_sew,
    output logic                      mul_is_mul,
    input  logic [31:0]               mul_result
);
    localparam int NW  = VLEN / 32;
    localparam int VLW = $clog2(VLEN / 8) + 1;
    localparam int CW  = $clog2(NW + 1);
    localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [VLW+2:0] NW_X = (VLW + 3)'(NW);
    localparam logic [CW-1:0]  NW_C = CW'(NW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sew_q, sew_d;
    logic [VLW-1:0]          vl_q, vl_d;
    logic [VLEN-1:0]         vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
    logic [CW-1:0]           nwords_q, nwords_d, cnt_q, cnt_d;
    logic [31:0]             op_a_q, op_a_d, op_b_q, op_b_d;
    logic                    busy_q, busy_d, done_q, done_d, is_mul_q, is_mul_d;
    logic [MUL_LAT:0]        pv_q, pv_d;
    logic [MUL_LAT:0][IW-1:0] pidx_q, pidx_d;

    logic [VLW+2:0]          scaled_s, nw_s;
    logic [CW-1:0]           nw_start_s;
    logic [IW-1:0]           cap_idx_s;

    // Byte b of word j is live when its element index (byte position >> sew) is below vl.
    function automatic logic byte_live(input logic [IW-1:0] j, input int b,
                                       input logic [1:0] s, input logic [VLW-1:0] n);
        int unsigned pos;
        pos = 32'(4 * int'(j) + b);
        return (pos >> s) < 32'(n);
    endfunction

    // Next-state, issue, latency-tracking and capture logic.
    always_comb begin
        state_d  = state_q;
        sew_d    = sew_q;
        vl_d     = vl_q;
        vs1_d    = vs1_q;
        vs2_d    = vs2_q;
        vd_d     = vd_q;
        nwords_d = nwords_q;
        cnt_d    = cnt_q;
        op_a_d   = 32'd0;
        op_b_d   = 32'd0;
        done_d   = 1'b0;
        pv_d     = {pv_q[MUL_LAT-1:0], 1'b0};
        pidx_d   = {pidx_q[MUL_LAT-1:0], pidx_q[0]};

        // words needed = ceil(vl * SEW / 32), clamped to the register width
        scaled_s   = ({3'b000, vl} << sew) + (VLW + 3)'(3);
        nw_s       = scaled_s >> 2;
        nw_start_s = (nw_s > NW_X) ? NW_C : nw_s[CW-1:0];
        cap_idx_s  = pidx_q[MUL_LAT];

        if (pv_q[MUL_LAT]) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_live(cap_idx_s, b, sew_q, vl_q)) begin
                    vd_d[32*int'(cap_idx_s) + 8*b +: 8] = mul_result[8*b +: 8];
                end else begin
                    vd_d[32*int'(cap_idx_s) + 8*b +: 8] = vd_q[32*int'(cap_idx_s) + 8*b +: 8];
                end
            end
        end else begin
            vd_d = vd_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sew_d    = sew;
                    vl_d     = vl;
                    vs1_d    = vs1;
                    vs2_d    = vs2;
                    vd_d     = vd_old;
                    nwords_d = nw_start_s;
                    if ((vl == VLW'(0)) || (sew == 2'b11)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        op_a_d    = vs1[31:0];
                        op_b_d    = vs2[31:0];
                        pv_d[0]   = 1'b1;
                        pidx_d[0] = IW'(0);
                        cnt_d     = CW'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == nwords_q) begin
                    state_d = S_DRAIN;
                end else begin
                    op_a_d    = vs1_q[32*int'(cnt_q) +: 32];
                    op_b_d    = vs2_q[32*int'(cnt_q) +: 32];
                    pv_d[0]   = 1'b1;
                    pidx_d[0] = cnt_q[IW-1:0];
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // the word being captured this cycle is the last one in flight
                if (pv_q[MUL_LAT-1:0] == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        is_mul_d = busy_d;
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q  <= S_IDLE;
            sew_q    <= 2'b00;
            vl_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            nwords_q <= '0;
            cnt_q    <= '0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_mul_q <= 1'b0;
            pv_q     <= '0;
            pidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            sew_q    <= sew_d;
            vl_q     <= vl_d;
            vs1_q    <= vs1_d;
            vs2_q    <= vs2_d;
            vd_q     <= vd_d;
            nwords_q <= nwords_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            is_mul_q <= is_mul_d;
            pv_q     <= pv_d;
            pidx_q   <= pidx_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign vd         = vd_q;
    assign mul_op_a   = op_a_q;
    assign mul_op_b   = op_b_q;
    assign mul_sew    = sew_q;
    assign mul_is_mul = is_mul_q;
endmodule
